// File: rtl/charger_pkg.sv
// Shared constants and state encoding for the coin-operated charger.
package charger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INPUT  = 2'd1,
    CHARGE = 2'd2
  } state_t;

  localparam int          AMOUNT_W   = 5;
  localparam logic [3:0]  DIGIT_MAX  = 4'd9;
  localparam logic [1:0]  MAX_DIGITS = 2'd2;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick divider; a synchronous clear restarts the count
// so the next tick is a full TICK_DIV cycles away.
module sec_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/charge_controller.sv
// Charger sequencing FSM: amount entry, timeout, timed charge.
// Optional: CHARGE_ABORT_EN lets clear abort a running charge.
module charge_controller
  import charger_pkg::*;
#(
  parameter int TICK_DIV        = 50000000,
  parameter int MAX_AMOUNT      = 20,
  parameter int SEC_PER_UNIT    = 2,
  parameter int INPUT_TIMEOUT_S = 10,
  parameter int TIME_W          = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          key_value,
  input  logic                press_num,
  input  logic                start,
  input  logic                clear,
  input  logic                confirm,
  output logic [1:0]          state,
  output logic [AMOUNT_W-1:0] amount,
  output logic [TIME_W-1:0]   remain_time,
  output logic                charging,
  output logic                charge_done
);

  localparam int TOW = $clog2(INPUT_TIMEOUT_S + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(INPUT_TIMEOUT_S - 1);
  localparam logic [AMOUNT_W-1:0] MAXA = AMOUNT_W'(MAX_AMOUNT);
  localparam logic [TIME_W-1:0] SPU = TIME_W'(SEC_PER_UNIT);

  state_t              r_state, w_state_nxt;
  logic [AMOUNT_W-1:0] r_amount, w_amount_nxt;
  logic [TIME_W-1:0]   r_remain, w_remain_nxt;
  logic                r_charging, w_charging_nxt;
  logic                r_done, w_done_nxt;
  logic [1:0]          r_digits, w_digits_nxt;
  logic [TOW-1:0]      r_to_cnt, w_to_nxt;
  logic                w_tick;
  logic                w_tclr;
  logic                w_key;
  logic [8:0]          w_acc;

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_tclr),
    .tick (w_tick)
  );

  assign w_tclr = (w_state_nxt != r_state);
  assign w_key  = start | clear | confirm | press_num;
  assign w_acc  = 9'(r_amount) * 9'd10 + 9'(key_value);

  always_comb begin
    w_state_nxt    = r_state;
    w_amount_nxt   = r_amount;
    w_remain_nxt   = r_remain;
    w_charging_nxt = r_charging;
    w_done_nxt     = 1'b0;
    w_digits_nxt   = r_digits;
    w_to_nxt       = r_to_cnt;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = INPUT;
          w_amount_nxt = '0;
          w_digits_nxt = '0;
          w_to_nxt     = '0;
        end
      end
      INPUT: begin
        if (w_key) begin
          w_to_nxt = '0;
        end else if (w_tick) begin
          if (r_to_cnt == TO_LAST) begin
            w_state_nxt  = IDLE;
            w_amount_nxt = '0;
            w_digits_nxt = '0;
            w_to_nxt     = '0;
          end else begin
            w_to_nxt = r_to_cnt + 1'b1;
          end
        end
        if (start || clear) begin
          w_amount_nxt = '0;
          w_digits_nxt = '0;
        end else if (confirm) begin
          if (r_amount != '0) begin
            w_state_nxt    = CHARGE;
            w_remain_nxt   = TIME_W'(r_amount) * SPU;
            w_charging_nxt = 1'b1;
          end
        end else if (press_num && (key_value <= DIGIT_MAX)
                     && (r_digits < MAX_DIGITS)) begin
          w_amount_nxt = (w_acc > 9'(MAX_AMOUNT)) ? MAXA
                                                  : w_acc[AMOUNT_W-1:0];
          w_digits_nxt = r_digits + 1'b1;
        end
      end
      CHARGE: begin
        if (w_tick) begin
          if (r_remain == TIME_W'(1)) begin
            w_state_nxt    = IDLE;
            w_remain_nxt   = '0;
            w_charging_nxt = 1'b0;
            w_done_nxt     = 1'b1;
            w_amount_nxt   = '0;
          end else begin
            w_remain_nxt = r_remain - 1'b1;
          end
        end
`ifdef CHARGE_ABORT_EN
        // Abort wins over a coincident final tick: no done pulse.
        if (clear) begin
          w_state_nxt    = IDLE;
          w_remain_nxt   = '0;
          w_charging_nxt = 1'b0;
          w_done_nxt     = 1'b0;
          w_amount_nxt   = '0;
        end
`endif
      end
      default: begin
        w_state_nxt    = IDLE;
        w_amount_nxt   = '0;
        w_remain_nxt   = '0;
        w_charging_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_amount   <= '0;
      r_remain   <= '0;
      r_charging <= 1'b0;
      r_done     <= 1'b0;
      r_digits   <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_amount   <= w_amount_nxt;
      r_remain   <= w_remain_nxt;
      r_charging <= w_charging_nxt;
      r_done     <= w_done_nxt;
      r_digits   <= w_digits_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  assign state       = r_state;
  assign amount      = r_amount;
  assign remain_time = r_remain;
  assign charging    = r_charging;
  assign charge_done = r_done;

endmodule

// File: tb/tb_charge_controller.sv
// Directed self-checking bench for charge_controller (TICK_DIV=10).
module tb_charge_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_value;
  logic       press_num;
  logic       start;
  logic       clear;
  logic       confirm;
  logic [1:0] state;
  logic [4:0] amount;
  logic [5:0] remain_time;
  logic       charging;
  logic       charge_done;

  int n_chk;
  int n_fail;

  charge_controller #(
    .TICK_DIV       (10),
    .MAX_AMOUNT     (20),
    .SEC_PER_UNIT   (2),
    .INPUT_TIMEOUT_S(10),
    .TIME_W         (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_value  (key_value),
    .press_num  (press_num),
    .start      (start),
    .clear      (clear),
    .confirm    (confirm),
    .state      (state),
    .amount     (amount),
    .remain_time(remain_time),
    .charging   (charging),
    .charge_done(charge_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic s, input logic c, input logic f,
                    input logic p, input logic [3:0] kv);
    start     = s;
    clear     = c;
    confirm   = f;
    press_num = p;
    key_value = kv;
    @(negedge clk);
    start     = 1'b0;
    clear     = 1'b0;
    confirm   = 1'b0;
    press_num = 1'b0;
    key_value = 4'd0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] kv);
    ev(1'b0, 1'b0, 1'b0, 1'b1, kv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    confirm = 1'b0;
    press_num = 1'b0;
    key_value = 4'd0;
    cyc(3);
    chk("rst_state", state, 0);
    chk("rst_amount", amount, 0);
    chk("rst_remain", remain_time, 0);
    chk("rst_charging", charging, 0);
    chk("rst_done", charge_done, 0);
    rst_n = 1'b1;
    cyc(2);

    // Digit in IDLE is ignored
    dig(4'd5);
    chk("idle_dig_amt", amount, 0);
    chk("idle_dig_st", state, 0);

    // Entry and full charge
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("start_st", state, 1);
    chk("start_amt", amount, 0);
    dig(4'd1);
    chk("dig1", amount, 1);
    dig(4'd5);
    chk("dig15", amount, 15);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("conf_st", state, 2);
    chk("conf_rem", remain_time, 30);
    chk("conf_chg", charging, 1);
    cyc(9);
    chk("rem_hold", remain_time, 30);
    cyc(1);
    chk("rem_29", remain_time, 29);
    cyc(289);
    chk("rem_1", remain_time, 1);
    chk("rem_1_chg", charging, 1);
    chk("rem_1_done", charge_done, 0);
    cyc(1);
    chk("done_pulse", charge_done, 1);
    chk("done_st", state, 0);
    chk("done_rem", remain_time, 0);
    chk("done_chg", charging, 0);
    chk("done_amt", amount, 0);
    cyc(1);
    chk("done_once", charge_done, 0);

    // Timeout from a fresh INPUT entry
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(99);
    chk("to_pre", state, 1);
    cyc(1);
    chk("to_idle", state, 0);

    // Digit on the 9th tick restarts the timeout
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(89);
    dig(4'd4);
    chk("to_dig_amt", amount, 4);
    chk("to_dig_st", state, 1);
    cyc(99);
    chk("to2_pre", state, 1);
    cyc(1);
    chk("to2_idle", state, 0);
    chk("to2_amt", amount, 0);

    // Saturation, digit limit, invalid key
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    dig(4'd9);
    chk("sat_9", amount, 9);
    dig(4'd9);
    chk("sat_20", amount, 20);
    dig(4'd3);
    chk("sat_3rd", amount, 20);
    dig(4'd12);
    chk("sat_kv12", amount, 20);
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("restart_amt", amount, 0);
    chk("restart_st", state, 1);
    dig(4'd12);
    chk("kv12", amount, 0);
    dig(4'd1);
    chk("lim_1", amount, 1);
    dig(4'd2);
    chk("lim_12", amount, 12);
    dig(4'd3);
    chk("lim_3rd", amount, 12);

    // Clear and zero confirm
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    dig(4'd7);
    chk("clr_7", amount, 7);
    ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("clr_amt", amount, 0);
    chk("clr_st", state, 1);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("zconf_st", state, 1);
    chk("zconf_chg", charging, 0);

    // Coincident events
    dig(4'd5);
    chk("sim_5", amount, 5);
    ev(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("clrconf_amt", amount, 0);
    chk("clrconf_st", state, 1);
    dig(4'd5);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    chk("confdig_st", state, 2);
    chk("confdig_rem", remain_time, 10);
    chk("confdig_amt", amount, 5);

    // Events during CHARGE
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("chg_start_st", state, 2);
    chk("chg_start_rem", remain_time, 10);
    dig(4'd1);
    chk("chg_dig_amt", amount, 5);
    ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef CHARGE_ABORT_EN
    chk("abort_st", state, 0);
    chk("abort_chg", charging, 0);
    chk("abort_rem", remain_time, 0);
    chk("abort_amt", amount, 0);
    chk("abort_done", charge_done, 0);
    ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    dig(4'd2);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("reent_st", state, 2);
    chk("reent_rem", remain_time, 4);
`else
    chk("clrign_st", state, 2);
    chk("clrign_chg", charging, 1);
    chk("clrign_rem", remain_time, 10);
    chk("clrign_done", charge_done, 0);
`endif

    // Asynchronous reset mid-charge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_amount", amount, 0);
    chk("arst_remain", remain_time, 0);
    chk("arst_charging", charging, 0);
    chk("arst_done", charge_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("post_state", state, 0);
    chk("post_done", charge_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
